fp16_add_seq: RTL

Multi-cycle IEEE-754 half-precision adder controller for the FloatAdd datapath. It sequences unpack, exponent alignment, an 11-bit significand add or subtract, normalization, and repack through an explicit FSM, one bit-shift per cycle. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/fp16_add_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fp16_add_seq.sv
// fp16_add_seq: multi-cycle half-precision adder.
// The FSM unpacks, aligns one bit per cycle, adds or subtracts, normalizes one
// bit per cycle, then holds the packed result until the consumer takes it.
// Rounding is truncation only. Subnormal inputs are flushed to zero, and NaN is
// never produced.
module fp16_add_seq #(
  parameter int MAX_ALIGN = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

  localparam logic [4:0] MAX_AL5 = 5'(MAX_ALIGN);
  localparam logic [4:0] EXP_INF = 5'h1f;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;      // result sign (sign of the larger operand)
  logic        sub_q, sub_d;        // operand signs differ
  logic [10:0] sig_a_q, sig_a_d;
  logic [10:0] sig_b_q, sig_b_d;
  logic [4:0]  exp_q, exp_d;
  logic [4:0]  diff_q, diff_d;
  logic [11:0] sum_q, sum_d;
  logic [15:0] res_q, res_d;

  // Unpack helpers. These are valid only while IDLE and are consumed on the accept edge.
  logic        a_inf, b_inf, swap;
  logic [14:0] mag_a, mag_b, mag_big, mag_small;
  logic        sgn_big;
  logic [4:0]  diff_full;

  // Unpack: flush subnormals, order the operands by magnitude, and cap the alignment
  always_comb begin
    a_inf     = (a[14:10] == EXP_INF);
    b_inf     = (b[14:10] == EXP_INF);
    mag_a     = (a[14:10] == 5'd0) ? 15'd0 : a[14:0];
    mag_b     = (b[14:10] == 5'd0) ? 15'd0 : b[14:0];
    swap      = (mag_b > mag_a);          // a tie keeps a as the larger operand
    mag_big   = swap ? mag_b : mag_a;
    mag_small = swap ? mag_a : mag_b;
    sgn_big   = swap ? b[15] : a[15];
    diff_full = mag_big[14:10] - mag_small[14:10];
  end

  // Next-state logic and datapath updates for every state
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    sig_a_d = sig_a_q;
    sig_b_d = sig_b_q;
    exp_d   = exp_q;
    diff_d  = diff_q;
    sum_d   = sum_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (a_inf || b_inf) begin
            // Infinity takes a's sign when a is infinite, otherwise b's sign.
            res_d   = {(a_inf ? a[15] : b[15]), EXP_INF, 10'd0};
            state_d = S_OUT;
          end else begin
            sign_d  = sgn_big;
            sub_d   = a[15] ^ b[15];
            exp_d   = mag_big[14:10];
            sig_a_d = (mag_big[14:10] == 5'd0) ? 11'd0 : {1'b1, mag_big[9:0]};
            sig_b_d = (mag_small[14:10] == 5'd0) ? 11'd0 : {1'b1, mag_small[9:0]};
            diff_d  = diff_full;
            if (diff_full >= MAX_AL5) begin
              // The smaller operand would shift out entirely.
              sig_b_d = 11'd0;
              diff_d  = 5'd0;
            end
            state_d = (diff_d != 5'd0) ? S_ALIGN : S_ADD;
          end
        end
      end
      S_ALIGN: begin
        sig_b_d = sig_b_q >> 1;
        diff_d  = diff_q - 5'd1;
        if (diff_q == 5'd1) state_d = S_ADD;
      end
      S_ADD: begin
        // sig_a >= sig_b after the swap, so the difference is never negative.
        sum_d   = sub_q ? ({1'b0, sig_a_q} - {1'b0, sig_b_q})
                        : ({1'b0, sig_a_q} + {1'b0, sig_b_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        if (sum_q == 12'd0) begin
          res_d   = 16'h0000;
          state_d = S_OUT;
        end else if (sum_q[11]) begin
          sum_d = sum_q >> 1;
          exp_d = exp_q + 5'd1;
          if (exp_d == EXP_INF) begin
            res_d   = {sign_q, EXP_INF, 10'd0};
            state_d = S_OUT;
          end
        end else if (!sum_q[10]) begin
          sum_d = sum_q << 1;
          exp_d = exp_q - 5'd1;
          if (exp_d == 5'd0) begin
            res_d   = 16'h0000;
            state_d = S_OUT;
          end
        end else begin
          res_d   = {sign_q, exp_q, sum_q[9:0]};
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      sig_a_q <= 11'd0;
      sig_b_q <= 11'd0;
      exp_q   <= 5'd0;
      diff_q  <= 5'd0;
      sum_q   <= 12'd0;
      res_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      sig_a_q <= sig_a_d;
      sig_b_q <= sig_b_d;
      exp_q   <= exp_d;
      diff_q  <= diff_d;
      sum_q   <= sum_d;
      res_q   <= res_d;
    end
  end

  // Handshake outputs are decoded directly from the registered state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_OUT);
    result    = res_q;
  end

endmodule
